// File: rtl/display_mux_scheduler.sv
// display_mux_scheduler: time-multiplexes NUM_DIGITS common-anode digits onto one
// shared hex decoder. Each enabled digit gets BLANK_CYCLES dark cycles followed by
// DWELL_CYCLES driven cycles. Digit values are snapshotted once per frame so a frame
// never mixes old and new data.
//
// The next-digit/wrap decision is taken on the clock edge that enters a digit's final
// dwell cycle, using digit_en as seen at that edge. This lets frame_done be a
// registered pulse that lines up with the final dwell cycle. The snapshot reload still
// happens on the edge that ends the frame.
module display_mux_scheduler #(
  parameter int NUM_DIGITS   = 2,
  parameter int DWELL_CYCLES = 4,
  parameter int BLANK_CYCLES = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic [4*NUM_DIGITS-1:0] digit_data,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  output logic [3:0]              hex_out,
  output logic [NUM_DIGITS-1:0]   disp,
  output logic                    blank,
  output logic                    frame_done
);

  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam bit HAS_BLANK = (BLANK_CYCLES > 0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } state_t;

  state_t                  r_state;
  logic [CNT_W-1:0]        r_cnt;
  logic [IDX_W-1:0]        r_idx;
  logic [4*NUM_DIGITS-1:0] r_snap;
  logic [IDX_W-1:0]        r_pendIdx;
  logic                    r_wrap;
  logic                    r_none;
  logic [3:0]              r_hex;
  logic [NUM_DIGITS-1:0]   r_disp;
  logic                    r_blank;
  logic                    r_frameDone;

  state_t                  w_nextState;
  logic [CNT_W-1:0]        w_nextCnt;
  logic [IDX_W-1:0]        w_nextIdx;
  logic [4*NUM_DIGITS-1:0] w_nextSnap;
  logic [IDX_W-1:0]        w_nextPendIdx;
  logic                    w_nextWrap;
  logic                    w_nextNone;
  logic [3:0]              w_nextHex;
  logic [NUM_DIGITS-1:0]   w_nextDisp;
  logic                    w_nextBlank;
  logic                    w_nextFrameDone;
  logic [NUM_DIGITS-1:0]   w_above;

  // Index of the lowest set bit of a mask (0 when the mask is empty).
  function automatic logic [IDX_W-1:0] lowestSet(input logic [NUM_DIGITS-1:0] mask);
    lowestSet = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      if (mask[i]) lowestSet = IDX_W'(i);
    end
  endfunction

  // State, counters, snapshot and all outputs are registered here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_snap      <= '0;
      r_pendIdx   <= '0;
      r_wrap      <= 1'b0;
      r_none      <= 1'b0;
      r_hex       <= 4'h0;
      r_disp      <= '0;
      r_blank     <= 1'b1;
      r_frameDone <= 1'b0;
    end else begin
      r_state     <= w_nextState;
      r_cnt       <= w_nextCnt;
      r_idx       <= w_nextIdx;
      r_snap      <= w_nextSnap;
      r_pendIdx   <= w_nextPendIdx;
      r_wrap      <= w_nextWrap;
      r_none      <= w_nextNone;
      r_hex       <= w_nextHex;
      r_disp      <= w_nextDisp;
      r_blank     <= w_nextBlank;
      r_frameDone <= w_nextFrameDone;
    end
  end

  // Next state, slot timing, upcoming-digit decision and the output values for the next cycle.
  always_comb begin
    w_nextState     = r_state;
    w_nextCnt       = r_cnt;
    w_nextIdx       = r_idx;
    w_nextSnap      = r_snap;
    w_nextPendIdx   = r_pendIdx;
    w_nextWrap      = r_wrap;
    w_nextNone      = r_none;
    w_nextFrameDone = 1'b0;
    w_nextDisp      = '0;
    w_nextHex       = r_hex;
    w_nextBlank     = 1'b1;
    w_above         = '0;

    unique case (r_state)
      ST_IDLE: begin
        if (en && (digit_en != '0)) begin
          w_nextSnap = digit_data;
          w_nextIdx  = lowestSet(digit_en);
          if (HAS_BLANK) begin
            w_nextState = ST_BLANK;
            w_nextCnt   = BLANK_LOAD;
          end else begin
            w_nextState = ST_SHOW;
            w_nextCnt   = DWELL_LOAD;
          end
        end
      end
      ST_BLANK: begin
        if (!en) begin
          w_nextState = ST_IDLE;
          w_nextCnt   = '0;
        end else if (r_cnt == '0) begin
          w_nextState = ST_SHOW;
          w_nextCnt   = DWELL_LOAD;
        end else begin
          w_nextCnt = r_cnt - 1'b1;
        end
      end
      ST_SHOW: begin
        if (!en) begin
          w_nextState = ST_IDLE;
          w_nextCnt   = '0;
        end else if (r_cnt != '0) begin
          w_nextCnt = r_cnt - 1'b1;
        end else if (r_none) begin
          w_nextState = ST_IDLE;
        end else begin
          w_nextIdx = r_pendIdx;
          if (r_wrap) w_nextSnap = digit_data;
          if (HAS_BLANK) begin
            w_nextState = ST_BLANK;
            w_nextCnt   = BLANK_LOAD;
          end else begin
            w_nextState = ST_SHOW;
            w_nextCnt   = DWELL_LOAD;
          end
        end
      end
      default: begin
        w_nextState = ST_IDLE;
        w_nextCnt   = '0;
      end
    endcase

    for (int i = 0; i < NUM_DIGITS; i++) begin
      w_above[i] = digit_en[i] && (i > int'(w_nextIdx));
    end

    if ((w_nextState == ST_SHOW) && (w_nextCnt == '0)) begin
      if (w_above != '0) begin
        w_nextPendIdx = lowestSet(w_above);
        w_nextWrap    = 1'b0;
        w_nextNone    = 1'b0;
      end else begin
        w_nextPendIdx   = lowestSet(digit_en);
        w_nextWrap      = 1'b1;
        w_nextNone      = (digit_en == '0);
        w_nextFrameDone = 1'b1;
      end
    end

    if (w_nextState == ST_SHOW) begin
      w_nextDisp[w_nextIdx] = 1'b1;
      w_nextHex             = w_nextSnap[{w_nextIdx, 2'b00} +: 4];
      w_nextBlank           = 1'b0;
    end
  end

  assign hex_out    = r_hex;
  assign disp       = r_disp;
  assign blank      = r_blank;
  assign frame_done = r_frameDone;

endmodule

// File: tb/tb_display_mux_scheduler.sv
// tb_display_mux_scheduler: table-driven and randomized checks of display_mux_scheduler
// in three parameterisations (2/4/1, 2/2/0 and 4/3/2).
module tb_display_mux_scheduler;

  logic clk = 1'b0;
  logic reset;

  logic       en0;
  logic [7:0] data0;
  logic [1:0] mask0;
  logic [3:0] hex0, hex1;
  logic [1:0] disp0, disp1;
  logic       blank0, blank1, fd0, fd1;

  logic        en2;
  logic [15:0] data2;
  logic [3:0]  mask2;
  logic [3:0]  hex2, disp2;
  logic        blank2, fd2;

  int errCount = 0;
  int checkCount = 0;

  typedef struct {
    logic [7:0] data;
    logic [1:0] expDisp;
    logic [3:0] expHex;
    logic       expBlank;
    logic       expFd;
  } vec_t;

  vec_t vecs[30];

  // Free-running clock shared by every instance.
  always #5 clk = ~clk;

  display_mux_scheduler #(.NUM_DIGITS(2), .DWELL_CYCLES(4), .BLANK_CYCLES(1)) dut0 (
    .clk(clk), .reset(reset), .en(en0), .digit_data(data0), .digit_en(mask0),
    .hex_out(hex0), .disp(disp0), .blank(blank0), .frame_done(fd0)
  );

  display_mux_scheduler #(.NUM_DIGITS(2), .DWELL_CYCLES(2), .BLANK_CYCLES(0)) dut1 (
    .clk(clk), .reset(reset), .en(en0), .digit_data(data0), .digit_en(mask0),
    .hex_out(hex1), .disp(disp1), .blank(blank1), .frame_done(fd1)
  );

  display_mux_scheduler #(.NUM_DIGITS(4), .DWELL_CYCLES(3), .BLANK_CYCLES(2)) dut2 (
    .clk(clk), .reset(reset), .en(en2), .digit_data(data2), .digit_en(mask2),
    .hex_out(hex2), .disp(disp2), .blank(blank2), .frame_done(fd2)
  );

  function automatic vec_t mkVec(input logic [7:0] d, input logic [1:0] ds, input logic [3:0] h,
                                 input logic b, input logic f);
    vec_t v;
    v.data = d; v.expDisp = ds; v.expHex = h; v.expBlank = b; v.expFd = f;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic e, input logic [7:0] d, input logic [1:0] m);
    en0 = e;
    data0 = d;
    mask0 = m;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Safety net so the run always ends.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Main test sequence.
  initial begin
    int fdSeen;
    int darkBad;
    int lastHex;
    logic [3:0] mask;
    int enList[$];
    logic [15:0] dataHist[$];

    vecs[0]  = mkVec(8'h23, 2'b00, 4'h0, 1'b1, 1'b0);
    vecs[1]  = mkVec(8'h23, 2'b01, 4'h3, 1'b0, 1'b0);
    vecs[2]  = mkVec(8'h23, 2'b01, 4'h3, 1'b0, 1'b0);
    vecs[3]  = mkVec(8'h23, 2'b01, 4'h3, 1'b0, 1'b0);
    vecs[4]  = mkVec(8'h23, 2'b01, 4'h3, 1'b0, 1'b0);
    vecs[5]  = mkVec(8'h23, 2'b00, 4'h3, 1'b1, 1'b0);
    vecs[6]  = mkVec(8'h23, 2'b10, 4'h2, 1'b0, 1'b0);
    vecs[7]  = mkVec(8'h23, 2'b10, 4'h2, 1'b0, 1'b0);
    vecs[8]  = mkVec(8'h23, 2'b10, 4'h2, 1'b0, 1'b0);
    vecs[9]  = mkVec(8'h23, 2'b10, 4'h2, 1'b0, 1'b1);
    vecs[10] = mkVec(8'h23, 2'b00, 4'h2, 1'b1, 1'b0);
    vecs[11] = mkVec(8'h23, 2'b01, 4'h3, 1'b0, 1'b0);
    vecs[12] = mkVec(8'hEF, 2'b01, 4'h3, 1'b0, 1'b0);
    vecs[13] = mkVec(8'hEF, 2'b01, 4'h3, 1'b0, 1'b0);
    vecs[14] = mkVec(8'hEF, 2'b01, 4'h3, 1'b0, 1'b0);
    vecs[15] = mkVec(8'hEF, 2'b00, 4'h3, 1'b1, 1'b0);
    vecs[16] = mkVec(8'hEF, 2'b10, 4'h2, 1'b0, 1'b0);
    vecs[17] = mkVec(8'hEF, 2'b10, 4'h2, 1'b0, 1'b0);
    vecs[18] = mkVec(8'hEF, 2'b10, 4'h2, 1'b0, 1'b0);
    vecs[19] = mkVec(8'hEF, 2'b10, 4'h2, 1'b0, 1'b1);
    vecs[20] = mkVec(8'hEF, 2'b00, 4'h2, 1'b1, 1'b0);
    vecs[21] = mkVec(8'hEF, 2'b01, 4'hF, 1'b0, 1'b0);
    vecs[22] = mkVec(8'hEF, 2'b01, 4'hF, 1'b0, 1'b0);
    vecs[23] = mkVec(8'hEF, 2'b01, 4'hF, 1'b0, 1'b0);
    vecs[24] = mkVec(8'hEF, 2'b01, 4'hF, 1'b0, 1'b0);
    vecs[25] = mkVec(8'hEF, 2'b00, 4'hF, 1'b1, 1'b0);
    vecs[26] = mkVec(8'hEF, 2'b10, 4'hE, 1'b0, 1'b0);
    vecs[27] = mkVec(8'hEF, 2'b10, 4'hE, 1'b0, 1'b0);
    vecs[28] = mkVec(8'hEF, 2'b10, 4'hE, 1'b0, 1'b0);
    vecs[29] = mkVec(8'hEF, 2'b10, 4'hE, 1'b0, 1'b1);

    reset = 1'b0;
    applyStimulus(1'b1, 8'h23, 2'b11);
    en2 = 1'b0; data2 = '0; mask2 = '0;
    repeat (3) tick();

    $display("[TB] reset state");
    checkOutput("reset_disp", 32'(disp0), 32'h0);
    checkOutput("reset_blank", 32'(blank0), 32'h1);
    checkOutput("reset_hex", 32'(hex0), 32'h0);
    checkOutput("reset_fd", 32'(fd0), 32'h0);
    checkOutput("reset_disp_b0", 32'(disp1), 32'h0);
    checkOutput("reset_blank_b0", 32'(blank1), 32'h1);

    reset = 1'b1;

    $display("[TB] two-digit frames with mid-frame data change");
    for (int t = 0; t < 30; t++) begin
      int start;
      int dig;
      logic [7:0] d;
      applyStimulus(1'b1, vecs[t].data, 2'b11);
      tick();
      checkOutput($sformatf("tbl_disp[%0d]", t), 32'(disp0), 32'(vecs[t].expDisp));
      checkOutput($sformatf("tbl_hex[%0d]", t), 32'(hex0), 32'(vecs[t].expHex));
      checkOutput($sformatf("tbl_blank[%0d]", t), 32'(blank0), 32'(vecs[t].expBlank));
      checkOutput($sformatf("tbl_fd[%0d]", t), 32'(fd0), 32'(vecs[t].expFd));
      // No-gap instance: slot of 2 cycles, frame of 4, snapshot at each frame start.
      dig = (t / 2) % 2;
      start = 4 * (t / 4);
      d = vecs[start].data;
      checkOutput($sformatf("b0_disp[%0d]", t), 32'(disp1), (dig == 0) ? 32'h1 : 32'h2);
      checkOutput($sformatf("b0_blank[%0d]", t), 32'(blank1), 32'h0);
      checkOutput($sformatf("b0_fd[%0d]", t), 32'(fd1), ((t % 4) == 3) ? 32'h1 : 32'h0);
      checkOutput($sformatf("b0_hex[%0d]", t), 32'(hex1), (dig == 0) ? 32'(d[3:0]) : 32'(d[7:4]));
    end

    $display("[TB] drop en during SHOW, then empty mask");
    applyStimulus(1'b1, 8'hEF, 2'b11);
    tick();
    checkOutput("next_frame_blank", 32'(disp0), 32'h0);
    tick();
    checkOutput("next_frame_disp", 32'(disp0), 32'h1);
    checkOutput("next_frame_hex", 32'(hex0), 32'hF);
    applyStimulus(1'b0, 8'hEF, 2'b11);
    tick();
    checkOutput("en_drop_disp", 32'(disp0), 32'h0);
    checkOutput("en_drop_blank", 32'(blank0), 32'h1);
    checkOutput("en_drop_fd", 32'(fd0), 32'h0);
    fdSeen = 0;
    darkBad = 0;
    repeat (10) begin
      tick();
      if (fd0 !== 1'b0) fdSeen++;
      if (disp0 !== 2'b00) darkBad++;
    end
    checkOutput("en_low_fd_count", 32'(fdSeen), 32'h0);
    checkOutput("en_low_dark_count", 32'(darkBad), 32'h0);
    applyStimulus(1'b1, 8'hEF, 2'b00);
    darkBad = 0;
    repeat (8) begin
      tick();
      if (disp0 !== 2'b00 || blank0 !== 1'b1 || fd0 !== 1'b0) darkBad++;
    end
    checkOutput("empty_mask_idle_count", 32'(darkBad), 32'h0);

    $display("[TB] single enabled digit");
    applyStimulus(1'b1, 8'hEF, 2'b10);
    for (int t = 0; t < 20; t++) begin
      tick();
      checkOutput($sformatf("single_disp[%0d]", t), 32'(disp0), ((t % 5) == 0) ? 32'h0 : 32'h2);
      checkOutput($sformatf("single_fd[%0d]", t), 32'(fd0), ((t % 5) == 4) ? 32'h1 : 32'h0);
      if ((t % 5) != 0) checkOutput($sformatf("single_hex[%0d]", t), 32'(hex0), 32'hE);
    end

    $display("[TB] asynchronous reset during SHOW");
    #1 reset = 1'b0;
    #1;
    checkOutput("async_reset_disp", 32'(disp0), 32'h0);
    checkOutput("async_reset_blank", 32'(blank0), 32'h1);
    checkOutput("async_reset_fd", 32'(fd0), 32'h0);
    #1 reset = 1'b1;
    applyStimulus(1'b0, 8'h00, 2'b00);

    $display("[TB] randomized runs against frame model");
    lastHex = 0;
    for (int run = 0; run < 8; run++) begin
      int n;
      int period;
      int len;
      mask = 4'($urandom_range(1, 15));
      enList.delete();
      for (int i = 0; i < 4; i++) if (mask[i]) enList.push_back(i);
      n = enList.size();
      period = 5 * n;
      len = 2 * period + int'($urandom_range(0, period - 1));
      dataHist.delete();
      for (int t = 0; t < len; t++) begin
        int p;
        int frameStart;
        int slot;
        int w;
        int dig;
        logic [15:0] snap;
        logic [3:0] expDisp;
        logic [3:0] expHex;
        logic expBlank;
        data2 = 16'($urandom);
        en2 = 1'b1;
        mask2 = mask;
        dataHist.push_back(data2);
        tick();
        p = t % period;
        frameStart = t - p;
        slot = p / 5;
        w = p % 5;
        dig = enList[slot];
        snap = dataHist[frameStart];
        if (w < 2) begin
          expDisp = 4'h0;
          expBlank = 1'b1;
          expHex = 4'(lastHex);
        end else begin
          expDisp = 4'(1 << dig);
          expBlank = 1'b0;
          expHex = snap[dig*4 +: 4];
          lastHex = int'(expHex);
        end
        checkOutput($sformatf("rnd%0d_disp[%0d]", run, t), 32'(disp2), 32'(expDisp));
        checkOutput($sformatf("rnd%0d_blank[%0d]", run, t), 32'(blank2), 32'(expBlank));
        checkOutput($sformatf("rnd%0d_hex[%0d]", run, t), 32'(hex2), 32'(expHex));
        checkOutput($sformatf("rnd%0d_fd[%0d]", run, t), 32'(fd2), (p == period - 1) ? 32'h1 : 32'h0);
      end
      en2 = 1'b0;
      tick();
      checkOutput($sformatf("rnd%0d_abort_disp", run), 32'(disp2), 32'h0);
      checkOutput($sformatf("rnd%0d_abort_blank", run), 32'(blank2), 32'h1);
      checkOutput($sformatf("rnd%0d_abort_fd", run), 32'(fd2), 32'h0);
      repeat (2) tick();
    end

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule

// File: doc/display_mux_scheduler.md
Name: display_mux_scheduler

Overview:
- Time-multiplexing controller that shares one hex-to-seven-segment decoder and one segment bus between NUM_DIGITS common-anode digits.
- Sits between the switch/adder datapath and the segment decoder in the lab2 dual-display top.
- Selects one enabled digit at a time and presents that digit's nibble to the decoder.
- Inserts a blanking gap between digit switches to suppress ghosting.
- Snapshots all digit values once per frame so a frame never mixes old and new data.

Parameters:
NUM_DIGITS, 2, number of multiplexed digits (2..8)
DWELL_CYCLES, 4, clk cycles each digit is driven (>=1)
BLANK_CYCLES, 1, clk cycles with all digits off between digits (>=0; 0 removes the gap)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous active-low reset
en  input  1  run enable
digit_data  input  4*NUM_DIGITS  nibble per digit; digit i = bits [4i+3:4i]
digit_en  input  NUM_DIGITS  per-digit enable mask
hex_out  output  4  nibble to shared segment decoder
disp  output  NUM_DIGITS  one-hot digit select, active-high; all-zero = dark
blank  output  1  high when no digit is driven
frame_done  output  1  one-cycle pulse on the final dwell cycle of each frame

Behaviour:
- Reset (reset=0, async; released synchronously by design convention):
  - state=IDLE, disp=0, hex_out=0, blank=1, frame_done=0.
  - Index counter, dwell/blank counter and snapshot register are all cleared.
  - Reset asserted mid-operation darkens all digits immediately, no clock needed.
- All outputs are registered.
- States: IDLE, BLANK, SHOW.
- IDLE:
  - disp=0, blank=1.
  - On a clk edge with en=1 and digit_en!=0: load snapshot<=digit_data and idx<=lowest set bit of digit_en.
  - Then enter BLANK, or enter SHOW directly when BLANK_CYCLES=0.
  - If en=1 and digit_en=0, remain in IDLE.
- BLANK:
  - disp=0, blank=1, hex_out holds its last value.
  - Lasts exactly BLANK_CYCLES cycles, then enters SHOW.
- SHOW:
  - disp=one-hot(idx), blank=0, hex_out=snapshot nibble idx.
  - Lasts exactly DWELL_CYCLES cycles.
  - On the last dwell cycle, evaluate the live digit_en:
    - If some enabled index > idx exists: idx<=lowest such index; go BLANK (or SHOW when BLANK_CYCLES=0).
    - Otherwise (wrap): frame_done=1 for that cycle; snapshot<=digit_data; idx<=lowest enabled index; go BLANK/SHOW.
    - If digit_en=0 at wrap: go IDLE.
- en=0 in BLANK or SHOW: next state is IDLE, disp=0 on the next edge, and the frame is abandoned without a frame_done pulse.
- Mask changes take effect only at digit boundaries. A digit already in SHOW completes its dwell even if its enable bit drops.
- Skipped (disabled) digits consume no time.
- Single enabled digit: that digit repeats, with a BLANK gap each frame and frame_done every dwell period.
- digit_data changes mid-frame are invisible until the next snapshot.
- Timing: per-digit slot = BLANK_CYCLES+DWELL_CYCLES cycles; frame period = slot × popcount(digit_en).
- First-assertion latency:
  - en sampled high at edge k, IDLE exits at edge k.
  - disp first asserts after edge k+BLANK_CYCLES.

Test Plan:
1. Reset low with en=1 and data present → disp=00, blank=1, hex_out=0, frame_done=0. Assert reset low during SHOW → disp=00 before the next clk edge.
2. Defaults, digit_data=8'h23, digit_en=2'b11, en=1 →
   - 1 blank cycle, then disp=01 / hex_out=3 for 4 cycles.
   - 1 blank cycle, then disp=10 / hex_out=2 for 4 cycles.
   - frame_done high on the last disp=10 cycle; 10-cycle period repeats.
3. Change digit_data to 8'hEF mid-frame → current frame still shows 3 then 2. Next frame shows F on digit0, then E on digit1.
4. digit_en=2'b10 → disp never equals 01. disp=10 for 4 cycles out of every 5; frame_done every 5 cycles.
5. BLANK_CYCLES=0, DWELL_CYCLES=2, both digits enabled → disp alternates 01,01,10,10 with blank never high.
6. Drop en during SHOW → disp=00 and state IDLE next cycle, no frame_done. digit_en=0 with en=1 → stays IDLE, disp=00.
